// File: rtl/spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// spi_xfer_sequencer
//
// Upstream feeder for the SPI master byte engine. Bytes arrive on a
// valid/ready stream into a TX FIFO. One master transfer is launched per
// byte (one-cycle start pulse plus data). The sequencer waits for the
// master's completion flag and returns the captured byte on a registered
// RX valid/ready output. A watchdog abandons a transfer that never
// completes.
//
// Parameters
//   DEPTH    TX FIFO entries (power of 2, >= 2)
//   TIMEOUT  clk cycles spent in WAIT before a transfer is abandoned (>= 32)
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   tx_valid/tx_data      upstream byte stream
//   tx_ready              FIFO not full (registered)
//   m_start/m_data        start pulse and byte to the master
//   m_finish/m_rx         master completion level and captured byte
//   rx_valid/rx_data      registered RX byte to downstream
//   rx_ready              downstream accept
//   busy                  not IDLE, or FIFO holds data
//   err_timeout           sticky watchdog expiry flag
//   err_overrun           sticky dropped-RX-byte flag
//   clr_err               synchronous clear of both sticky flags
//
// Optional feature (macro SPI_SEQ_LEVEL_EN)
//   Adds output fifo_level [$clog2(DEPTH):0], the registered FIFO occupancy.
// ---------------------------------------------------------------------------
module spi_xfer_sequencer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid,
   input  logic [7:0]            tx_data,
   output logic                  tx_ready,
   output logic                  m_start,
   output logic [7:0]            m_data,
   input  logic                  m_finish,
   input  logic [7:0]            m_rx,
   output logic                  rx_valid,
   output logic [7:0]            rx_data,
   input  logic                  rx_ready,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_overrun,
   input  logic                  clr_err
`ifdef SPI_SEQ_LEVEL_EN
   ,
   output logic [$clog2(DEPTH):0] fifo_level
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int WDW = $clog2(TIMEOUT);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_GUARD,
      S_WAIT,
      S_CAPTURE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [7:0]      r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic            r_tx_ready;
   logic            r_m_start;
   logic [7:0]      r_m_data;
   logic            r_finish_d;
   logic [WDW-1:0]  r_wd;
   logic            r_rx_valid;
   logic [7:0]      r_rx_data;
   logic            r_err_to;
   logic            r_err_ov;

   logic            w_push;
   logic            w_empty;
   logic            w_done;
   logic            w_wd_exp;
   logic [PW-1:0]   w_wr_nxt;
   logic [PW-1:0]   w_rd_nxt;
   logic [PW-1:0]   w_cnt_nxt;

   // FSM output decodes
   logic            w_launch;
   logic            w_wd_run;
   logic            w_timeout;
   logic            w_capture;
   logic            w_rx_load;
   logic            w_rx_drop;

   assign w_push   = tx_valid & r_tx_ready;
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   // Rising edge of the master's completion level
   assign w_done   = m_finish & ~r_finish_d;
   assign w_wd_exp = (r_wd == WD_LAST);

   assign w_wr_nxt  = r_wr_ptr + PW'(w_push);
   assign w_rd_nxt  = r_rd_ptr + PW'(w_launch);
   assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (!w_empty) w_state_nxt = S_LAUNCH;
         S_LAUNCH:  w_state_nxt = S_GUARD;
         // m_finish from the previous transfer is still high here; it only
         // drops after the master sees the start pulse.
         S_GUARD:   w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (w_done)        w_state_nxt = S_CAPTURE;
            else if (w_wd_exp) w_state_nxt = S_IDLE;
         end
         S_CAPTURE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------
   always_comb begin
      w_launch  = 1'b0;
      w_wd_run  = 1'b0;
      w_timeout = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_LAUNCH:  w_launch  = 1'b1;
         S_WAIT: begin
            w_wd_run  = 1'b1;
            // A completion in the last watchdog cycle still counts
            w_timeout = w_wd_exp & ~w_done;
         end
         S_CAPTURE: w_capture = 1'b1;
         default: ;
      endcase
   end

   // The RX slot can take a new byte if it is empty or being drained now
   assign w_rx_load = w_capture & (~r_rx_valid | rx_ready);
   assign w_rx_drop = w_capture & r_rx_valid & ~rx_ready;

   // ------------------------------------------------------------------
   // FIFO storage (contents need no reset; pointers define validity)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_tx_ready <= 1'b1;
      end else begin
         r_wr_ptr   <= w_wr_nxt;
         r_rd_ptr   <= w_rd_nxt;
         // Registered from the updated count, so a push arriving while full
         // is refused even if a pop happens in the same cycle.
         r_tx_ready <= (w_cnt_nxt != PW'(DEPTH));
      end
   end

   // ------------------------------------------------------------------
   // Master interface and watchdog
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_start  <= 1'b0;
         r_m_data   <= '0;
         r_finish_d <= 1'b0;
         r_wd       <= '0;
      end else begin
         r_m_start  <= w_launch;
         r_finish_d <= m_finish;
         if (w_launch) r_m_data <= r_mem[r_rd_ptr[AW-1:0]];
         if (w_launch)      r_wd <= '0;
         else if (w_wd_run) r_wd <= r_wd + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // RX output register and sticky error flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_err_to   <= 1'b0;
         r_err_ov   <= 1'b0;
      end else begin
         if (w_rx_load) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= m_rx;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         // A same-cycle set beats clr_err
         if (w_timeout)    r_err_to <= 1'b1;
         else if (clr_err) r_err_to <= 1'b0;
         if (w_rx_drop)    r_err_ov <= 1'b1;
         else if (clr_err) r_err_ov <= 1'b0;
      end
   end

`ifdef SPI_SEQ_LEVEL_EN
   logic [PW-1:0] r_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_level <= '0;
      else     r_level <= w_cnt_nxt;
   end

   assign fifo_level = r_level;
`endif

   assign tx_ready    = r_tx_ready;
   assign m_start     = r_m_start;
   assign m_data      = r_m_data;
   assign rx_valid    = r_rx_valid;
   assign rx_data     = r_rx_data;
   assign busy        = (r_state != S_IDLE) | ~w_empty;
   assign err_timeout = r_err_to;
   assign err_overrun = r_err_ov;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_sequencer
//
// Scoreboard bench for spi_xfer_sequencer. Stimulus drives on the falling
// edge; a monitor samples every signal 1 time unit before each rising edge,
// i.e. exactly the values the DUT clocks in. A behavioural SPI master
// answers each start pulse with m_rx = m_data ^ 8'h99 after a programmable
// delay. Expected launch bytes and expected RX bytes live in queues.
// Optional macro SPI_SEQ_LEVEL_EN enables fifo_level checks.
// ---------------------------------------------------------------------------
module tb_spi_xfer_sequencer;

   localparam int DEPTH = 8;
   localparam int TMO   = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_ready;
   logic       m_start;
   logic [7:0] m_data;
   logic       m_finish = 1'b0;
   logic [7:0] m_rx = '0;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready = 1'b1;
   logic       busy;
   logic       err_timeout;
   logic       err_overrun;
   logic       clr_err = 1'b0;
`ifdef SPI_SEQ_LEVEL_EN
   logic [3:0] fifo_level;
`endif

   spi_xfer_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .m_start(m_start), .m_data(m_data), .m_finish(m_finish), .m_rx(m_rx),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun),
      .clr_err(clr_err)
`ifdef SPI_SEQ_LEVEL_EN
      , .fifo_level(fifo_level)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [7:0] q_tx[$];     // accepted bytes, in expected launch order
   logic [7:0] q_rx[$];     // bytes the master returned, expected downstream
   int  cnt      = 0;       // model FIFO occupancy
   int  n_start  = 0;
   bit  prev_start = 0;
   bit  saw_full = 0;
   int  lvl_peak = 0;

   // ---------------- behavioural SPI master ----------------
   int         mdly   = 5;
   bit         m_rand = 0;
   bit         m_hang = 0;     // one-shot: next transfer never completes
   bit         m_armed = 0;
   int         m_cnt  = 0;
   logic [7:0] m_lat  = '0;

   always @(negedge clk or posedge rst) begin
      if (rst) begin
         m_finish = 1'b0;
         m_rx     = '0;
         m_armed  = 0;
      end else if (m_start) begin
         m_finish = 1'b0;
         m_lat    = m_data;
         m_armed  = !m_hang;
         m_hang   = 0;
         m_cnt    = m_rand ? int'($urandom_range(2, 15)) : mdly;
      end else if (m_armed) begin
         chk("m_data_hold", int'(m_data), int'(m_lat));
         m_cnt--;
         if (m_cnt <= 0) begin
            m_finish = 1'b1;
            m_rx     = m_lat ^ 8'h99;
            m_armed  = 0;
            q_rx.push_back(m_rx);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int exp;
      forever begin
         @(negedge clk); #4;
         if (rst) begin
            prev_start = 0;
         end else begin
            if (m_start) begin
               n_start++;
               chk("m_start_1cyc", int'(prev_start), 0);
               exp = (q_tx.size() > 0) ? int'(q_tx.pop_front()) : -1;
               chk("launch_data", int'(m_data), exp);
               if (cnt > 0) cnt--;
            end
            prev_start = m_start;
            chk("tx_ready", int'(tx_ready), int'(cnt < DEPTH));
            if (!tx_ready) saw_full = 1;
`ifdef SPI_SEQ_LEVEL_EN
            chk("fifo_level", int'(fifo_level), cnt);
            if (cnt > lvl_peak) lvl_peak = cnt;
`endif
            if (tx_valid && cnt < DEPTH) begin
               q_tx.push_back(tx_data);
               cnt++;
            end
            if (rx_valid && rx_ready) begin
               exp = (q_rx.size() > 0) ? int'(q_rx.pop_front()) : -1;
               chk("rx_data", int'(rx_data), exp);
            end
         end
      end
   end

   // ---------------- stimulus helpers (call on a falling edge) ----------------
   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      #4;
      while (!tx_ready && n < 1500) begin
         @(negedge clk); #4; n++;
      end
      if (n >= 1500) chk("push_accept", 0, 1);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit rx_empty);
      int n = 0;
      @(negedge clk); #4;
      while ((busy || q_tx.size() != 0 || m_armed || (rx_empty && rx_valid)) && n < 1500) begin
         @(negedge clk); #4; n++;
      end
      chk("idle_reached", int'(n < 1500), 1);
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_tx_ready"}, int'(tx_ready), 1);
      chk({tag, "_m_start"}, int'(m_start), 0);
      chk({tag, "_m_data"}, int'(m_data), 0);
      chk({tag, "_rx_valid"}, int'(rx_valid), 0);
      chk({tag, "_rx_data"}, int'(rx_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_err_timeout"}, int'(err_timeout), 0);
      chk({tag, "_err_overrun"}, int'(err_overrun), 0);
`ifdef SPI_SEQ_LEVEL_EN
      chk({tag, "_fifo_level"}, int'(fifo_level), 0);
`endif
   endtask

   // wait for the n-th rising edge of m_finish; returns at a sample point
   task automatic wait_finish_rises(input int want, output int got);
      int  n = 0;
      bit  pf;
      got = 0;
      #4;
      pf = m_finish;
      while (got < want && n < 1500) begin
         @(negedge clk); #4; n++;
         if (m_finish && !pf) got++;
         pf = m_finish;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int n0;
      int nr;

      repeat (3) @(negedge clk);
      #1;
      check_reset("rst0");
      #1 rst = 1'b0;
      @(negedge clk);

      // 1: single byte, master answers after 20 cycles
      mdly = 20;
      n0 = n_start;
      push_byte(8'hA5);
      n = 1; #4;
      while (!m_start && n < 50) begin @(negedge clk); #4; n++; end
      // pushed at sample 0; m_start rises 2 edges after the push edge
      chk("t1_start_lat", n, 3);
      chk("t1_m_data", int'(m_data), 8'hA5);
      n = 0;
      while (!m_finish && n < 100) begin @(negedge clk); #4; n++; end
      n = 0;
      while (!rx_valid && n < 10) begin @(negedge clk); #4; n++; end
      chk("t1_rx_lat", n, 2);
      chk("t1_rx_data", int'(rx_data), 8'h3C);
      @(negedge clk);
      wait_idle(1);
      chk("t1_nstart", n_start - n0, 1);
      chk("t1_busy", int'(busy), 0);

      // 2: ten bytes back-to-back, FIFO must fill
      mdly = 12; saw_full = 0; lvl_peak = 0; n0 = n_start;
      for (int i = 0; i < 10; i++) push_byte(8'(i));
      wait_idle(1);
      chk("t2_saw_full", int'(saw_full), 1);
      chk("t2_launches", n_start - n0, 10);
`ifdef SPI_SEQ_LEVEL_EN
      chk("t2_level_peak", lvl_peak, DEPTH);
`endif

      // 3: master hangs on first byte; watchdog recovers, next byte proceeds
      mdly = 6; m_hang = 1;
      push_byte(8'h40);
      push_byte(8'h41);
      n = 0; #4;
      while (!m_start && n < 50) begin @(negedge clk); #4; n++; end
      n = 0;
      while (!err_timeout && n < TMO + 20) begin @(negedge clk); #4; n++; end
      chk("t3_tmo_lat", n, TMO + 1);
      @(negedge clk);
      wait_idle(1);
      chk("t3_err_sticky", int'(err_timeout), 1);
      clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      #4 chk("t3_err_clr", int'(err_timeout), 0);
      @(negedge clk);

      // 4a: rx_ready held low across two transfers -> overrun
      mdly = 4; rx_ready = 1'b0;
      push_byte(8'h88);
      push_byte(8'hBB);
      wait_idle(0);
      #4;
      chk("t4_rx_valid", int'(rx_valid), 1);
      chk("t4_rx_keep", int'(rx_data), 8'h11);
      chk("t4_overrun", int'(err_overrun), 1);
      void'(q_rx.pop_back());          // 0x22 was dropped by design
      @(negedge clk); rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0; clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      #4 chk("t4_ovr_clr", int'(err_overrun), 0);
      @(negedge clk);

      // 4b: accept coincides with second capture -> reload, no overrun
      push_byte(8'h88);
      push_byte(8'hBB);
      wait_finish_rises(2, nr);
      chk("t4b_finishes", nr, 2);
      @(negedge clk); rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      #4;
      chk("t4b_rx_valid", int'(rx_valid), 1);
      chk("t4b_rx_data", int'(rx_data), 8'h22);
      chk("t4b_no_ovr", int'(err_overrun), 0);
      @(negedge clk); rx_ready = 1'b1;
      wait_idle(1);

      // 6a: push coinciding with pop at DEPTH-1
      mdly = 25;
      for (int i = 0; i < DEPTH; i++) push_byte(8'hE0 + 8'(i));
      wait_finish_rises(1, nr);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); tx_valid = 1'b1; tx_data = 8'hEE;
      @(negedge clk); tx_valid = 1'b0;
      #4;
      chk("t6_ready_at_dm1", int'(tx_ready), 1);
`ifdef SPI_SEQ_LEVEL_EN
      chk("t6_level_dm1", int'(fifo_level), DEPTH - 1);
`endif
      @(negedge clk);
      wait_idle(1);

      // 6b: 40 random bytes with random gaps and master delays (pointer wrap)
      m_rand = 1; n0 = n_start;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         push_byte(8'($urandom));
      end
      wait_idle(1);
      m_rand = 0;
      chk("t6_launches", n_start - n0, 40);

      // 5: async reset during WAIT with 3 bytes queued
      mdly = 30;
      for (int i = 0; i < 4; i++) push_byte(8'h51 + 8'(i));
      n = 0; #4;
      while (!m_start && n < 50) begin @(negedge clk); #4; n++; end
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset("t5_async");
      q_tx.delete();
      q_rx.delete();
      cnt = 0;
      n0 = n_start;
      @(negedge clk); #2 rst = 1'b0;
      repeat (20) @(negedge clk);
      #4;
      chk("t5_no_start", n_start - n0, 0);
      chk("t5_busy", int'(busy), 0);
      @(negedge clk);
      mdly = 5;
      push_byte(8'h77);
      wait_idle(1);

      chk("end_q_tx", q_tx.size(), 0);
      chk("end_q_rx", q_rx.size(), 0);
      chk("end_err_to", int'(err_timeout), 0);
      chk("end_err_ov", int'(err_overrun), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
